// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use detector: flags an ID instruction that reads the destination of a load in EX.
module hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_to_reg,
  input  logic       ex_nop,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 is never really written, so a load into it cannot create a hazard
  assign load_use = ex_mem_to_reg && !ex_nop && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch flush, memory wait, ebreak halt.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_to_reg,
  input  logic        ex_nop,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  input  logic        mem_ebreak,
  input  logic        mem_nop,
  input  logic        resume,
  output logic        pc_stop,
  output logic        ifid_stop,
  output logic        idex_stop,
  output logic        exmem_stop,
  output logic        memwb_stop,
  output logic        ifid_clr,
  output logic        idex_clr,
  output logic        exmem_clr,
  output logic        memwb_clr,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam bit              WAIT_EN  = (MEM_LAT > 0);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q;
  logic             load_use;

  hazard_unit u_hazard (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_nop        (ex_nop),
    .load_use      (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALT);
    end
  end

  assign halted = halted_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_stop    = 1'b0;
    ifid_stop  = 1'b0;
    idex_stop  = 1'b0;
    exmem_stop = 1'b0;
    memwb_stop = 1'b0;
    ifid_clr   = 1'b0;
    idex_clr   = 1'b0;
    exmem_clr  = 1'b0;
    memwb_clr  = 1'b0;

    if (rst) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
      memwb_clr = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_ebreak && !mem_nop) begin
            pc_stop   = 1'b1;
            ifid_stop = 1'b1;
            idex_stop = 1'b1;
            exmem_clr = 1'b1;
            state_d   = HALT;
          end else if (WAIT_EN && mem_access && !mem_nop) begin
            pc_stop    = 1'b1;
            ifid_stop  = 1'b1;
            idex_stop  = 1'b1;
            exmem_stop = 1'b1;
            memwb_clr  = 1'b1;
            cnt_d      = CNT_INIT;
            state_d    = MEM_WAIT;
          end else if (ex_branch_taken && !ex_nop) begin
            // wrong-path ID instruction is discarded, so any load-use on it is moot
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
          end else if (load_use) begin
            pc_stop   = 1'b1;
            ifid_stop = 1'b1;
            idex_clr  = 1'b1;
          end
        end
        MEM_WAIT: begin
          // the first stall cycle was spent in RUN, so cnt==0 is the release cycle
          if (cnt_q != '0) begin
            pc_stop    = 1'b1;
            ifid_stop  = 1'b1;
            idex_stop  = 1'b1;
            exmem_stop = 1'b1;
            memwb_clr  = 1'b1;
            cnt_d      = cnt_q - CNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
        HALT: begin
          if (resume) begin
            state_d = RUN;
          end else begin
            pc_stop    = 1'b1;
            ifid_stop  = 1'b1;
            idex_stop  = 1'b1;
            exmem_stop = 1'b1;
            memwb_stop = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q, flush_q;

  // ifid_clr outside reset only comes from a taken-branch flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_stop && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (ifid_clr && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'b0;
  assign flush_count  = 32'b0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: MEM_LAT=2 main instance plus a MEM_LAT=0 instance.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_to_reg, ex_nop, ex_branch_taken;
  logic        mem_access, mem_ebreak, mem_nop, resume;

  logic        pc_stop, ifid_stop, idex_stop, exmem_stop, memwb_stop;
  logic        ifid_clr, idex_clr, exmem_clr, memwb_clr, halted;
  logic [31:0] stall_cycles, flush_count;

  logic        pc_stop0, ifid_stop0, idex_stop0, exmem_stop0, memwb_stop0;
  logic        ifid_clr0, idex_clr0, exmem_clr0, memwb_clr0, halted0;
  logic [31:0] stall_cycles0, flush_count0;

  int checks   = 0;
  int failures = 0;

  // {pc,ifid,idex,exmem,memwb stop, ifid,idex,exmem,memwb clr}
  localparam logic [8:0] O_NONE = 9'b00000_0000;
  localparam logic [8:0] O_RST  = 9'b00000_1111;
  localparam logic [8:0] O_LU   = 9'b11000_0100;
  localparam logic [8:0] O_BR   = 9'b00000_1100;
  localparam logic [8:0] O_MW   = 9'b11110_0001;
  localparam logic [8:0] O_EB   = 9'b11100_0010;
  localparam logic [8:0] O_HALT = 9'b11111_0000;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg), .ex_nop(ex_nop), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ebreak(mem_ebreak), .mem_nop(mem_nop), .resume(resume),
    .pc_stop(pc_stop), .ifid_stop(ifid_stop), .idex_stop(idex_stop), .exmem_stop(exmem_stop),
    .memwb_stop(memwb_stop), .ifid_clr(ifid_clr), .idex_clr(idex_clr), .exmem_clr(exmem_clr),
    .memwb_clr(memwb_clr), .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_ctrl #(.MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg), .ex_nop(ex_nop), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ebreak(mem_ebreak), .mem_nop(mem_nop), .resume(resume),
    .pc_stop(pc_stop0), .ifid_stop(ifid_stop0), .idex_stop(idex_stop0), .exmem_stop(exmem_stop0),
    .memwb_stop(memwb_stop0), .ifid_clr(ifid_clr0), .idex_clr(idex_clr0), .exmem_clr(exmem_clr0),
    .memwb_clr(memwb_clr0), .halted(halted0), .stall_cycles(stall_cycles0), .flush_count(flush_count0)
  );

  logic [8:0] outs, outs0;
  assign outs  = {pc_stop, ifid_stop, idex_stop, exmem_stop, memwb_stop,
                  ifid_clr, idex_clr, exmem_clr, memwb_clr};
  assign outs0 = {pc_stop0, ifid_stop0, idex_stop0, exmem_stop0, memwb_stop0,
                  ifid_clr0, idex_clr0, exmem_clr0, memwb_clr0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_to_reg = 1'b0; ex_nop = 1'b0; ex_branch_taken = 1'b0;
    mem_access = 1'b0; mem_ebreak = 1'b0; mem_nop = 1'b0; resume = 1'b0;
  endtask

  // inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge
  task automatic next_cycle();
    @(negedge clk);
  endtask

  int stall_total;

  initial begin
    rst = 1'b1;
    idle_inputs();
    mem_access = 1'b1;
    ex_branch_taken = 1'b1;
    next_cycle(); #1;
    check_eq("reset_outs", 32'(outs), 32'(O_RST));
    check_eq("reset_halted", 32'(halted), 32'd0);
    check_eq("reset_stall_cnt", stall_cycles, 32'd0);
    check_eq("reset_flush_cnt", flush_count, 32'd0);

    next_cycle(); rst = 1'b0; idle_inputs(); #1;
    check_eq("idle", 32'(outs), 32'(O_NONE));

    // load-use on rs2
    next_cycle(); ex_mem_to_reg = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; #1;
    check_eq("lu_rs2", 32'(outs), 32'(O_LU));
    next_cycle(); ex_nop = 1'b1; #1;
    check_eq("lu_one_cycle", 32'(outs), 32'(O_NONE));

    next_cycle(); idle_inputs(); ex_mem_to_reg = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1; #1;
    check_eq("lu_x0", 32'(outs), 32'(O_NONE));

    next_cycle(); idle_inputs(); ex_mem_to_reg = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; #1;
    check_eq("lu_rs1", 32'(outs), 32'(O_LU));
    next_cycle(); id_uses_rs1 = 1'b0; #1;
    check_eq("lu_rs1_unused", 32'(outs), 32'(O_NONE));

    // branch wins over load-use
    next_cycle(); idle_inputs(); ex_mem_to_reg = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    ex_branch_taken = 1'b1; #1;
    check_eq("br_over_lu", 32'(outs), 32'(O_BR));

`ifdef PIPE_CTRL_PERF_EN
    next_cycle(); idle_inputs(); #1;
    check_eq("perf_stall_2", stall_cycles, 32'd2);
    check_eq("perf_flush_1", flush_count, 32'd1);
`endif

    // two back-to-back loads in MEM; MEM_LAT=0 instance never stalls
    next_cycle(); idle_inputs(); mem_access = 1'b1; #1;
    stall_total = 0;
    check_eq("mw1_a", 32'(outs), 32'(O_MW));
    check_eq("lat0_store_a", 32'(outs0), 32'(O_NONE));
    if (pc_stop) stall_total++;
    next_cycle(); #1;
    check_eq("mw1_b", 32'(outs), 32'(O_MW));
    check_eq("lat0_store_b", 32'(outs0), 32'(O_NONE));
    if (pc_stop) stall_total++;
    next_cycle(); #1;
    check_eq("mw1_release", 32'(outs), 32'(O_NONE));
    check_eq("lat0_store_c", 32'(outs0), 32'(O_NONE));
    if (pc_stop) stall_total++;
    next_cycle(); #1;
    check_eq("mw2_a", 32'(outs), 32'(O_MW));
    if (pc_stop) stall_total++;
    next_cycle(); ex_branch_taken = 1'b1; #1;
    check_eq("mw2_b_branch_frozen", 32'(outs), 32'(O_MW));
    if (pc_stop) stall_total++;
    next_cycle(); #1;
    check_eq("mw2_release", 32'(outs), 32'(O_NONE));
    if (pc_stop) stall_total++;
    check_eq("mw_stall_total", 32'(stall_total), 32'd4);
    next_cycle(); mem_access = 1'b0; #1;
    check_eq("branch_after_wait", 32'(outs), 32'(O_BR));

    // resume outside HALT is ignored
    next_cycle(); idle_inputs(); resume = 1'b1; #1;
    check_eq("resume_in_run", 32'(outs), 32'(O_NONE));
    next_cycle(); resume = 1'b0; #1;
    check_eq("resume_in_run_halted", 32'(halted), 32'd0);

    // ebreak beats a branch, then halt and resume
    next_cycle(); mem_ebreak = 1'b1; ex_branch_taken = 1'b1; #1;
    check_eq("ebreak", 32'(outs), 32'(O_EB));
    check_eq("ebreak_not_halted_yet", 32'(halted), 32'd0);
    next_cycle(); mem_ebreak = 1'b0; mem_nop = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      check_eq("halt_outs", 32'(outs), 32'(O_HALT));
      check_eq("halt_flag", 32'(halted), 32'd1);
      next_cycle(); #1;
    end
    resume = 1'b1; #1;
    check_eq("resume_outs", 32'(outs), 32'(O_NONE));
    check_eq("resume_halted_still", 32'(halted), 32'd1);
    next_cycle(); resume = 1'b0; mem_nop = 1'b0; #1;
    check_eq("after_resume_halted", 32'(halted), 32'd0);
    check_eq("after_resume_branch", 32'(outs), 32'(O_BR));

    // reset in the middle of a memory wait
    next_cycle(); idle_inputs(); mem_access = 1'b1; #1;
    check_eq("mw3_a", 32'(outs), 32'(O_MW));
    next_cycle(); rst = 1'b1; #1;
    check_eq("rst_mid_wait", 32'(outs), 32'(O_RST));
    check_eq("rst_mid_wait_stall_cnt", stall_cycles, 32'd0);
    check_eq("rst_mid_wait_flush_cnt", flush_count, 32'd0);
    next_cycle(); rst = 1'b0; idle_inputs(); ex_branch_taken = 1'b1; #1;
    check_eq("run_after_rst", 32'(outs), 32'(O_BR));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage RV32I pipeline. It drives the stop/clr inputs of the PC register and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves load-use hazards, taken-branch flushes, fixed-latency data-memory waits and ebreak halt/resume. Stop has priority over clr inside every pipeline register, so this block never relies on asserting both on one register.

Parameters:
MEM_LAT, 2, extra stall cycles per data-memory access in MEM (0 = single-cycle memory, no wait).
CNT_W, $clog2(MEM_LAT+1) (min 1), width of the wait counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
id_rs1, id_rs2  in  5  source registers of the instruction in ID.
id_uses_rs1, id_uses_rs2  in  1  the ID instruction reads rs1/rs2.
ex_rd  in  5  destination of the instruction in EX.
ex_mem_to_reg  in  1  EX instruction is a load.
ex_nop  in  1  EX slot holds a bubble.
ex_branch_taken  in  1  EX resolved a taken branch/jump (PC redirect).
mem_access  in  1  MEM instruction is a load or store.
mem_ebreak  in  1  MEM instruction is ebreak.
mem_nop  in  1  MEM slot holds a bubble.
resume  in  1  debugger continue, sampled only in HALT.
pc_stop, ifid_stop, idex_stop, exmem_stop, memwb_stop  out  1  hold the register.
ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1  load a bubble.
halted  out  1  registered; 1 while in HALT.
stall_cycles, flush_count  out  32  performance counters (see Optional Feature).

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Wait counter cnt[CNT_W-1:0].
- While rst is high: state=RUN, cnt=0, halted=0, all *_stop=0, all *_clr=1.
- Outputs are combinational from state and inputs, except halted. Every output not listed below is 0.
- RUN. The first matching row applies:
  1. mem_ebreak & ~mem_nop: pc/ifid/idex stop=1, exmem_clr=1 (ebreak passes to WB, bubble into MEM). Next state HALT.
  2. mem_access & ~mem_nop & MEM_LAT>0: pc/ifid/idex/exmem stop=1, memwb_clr=1. Load cnt=MEM_LAT-1. Next state MEM_WAIT.
  3. ex_branch_taken & ~ex_nop: ifid_clr=1, idex_clr=1. PC is not stopped, so the redirect loads.
  4. Load-use (ex_mem_to_reg & ~ex_nop & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))): pc_stop=1, ifid_stop=1, idex_clr=1. Single cycle, no state change.
- MEM_WAIT:
  - cnt!=0: same outputs as RUN row 2; cnt decrements.
  - cnt==0: all outputs 0 (the access advances into MEM_WB); next state RUN.
  - Total stall is exactly MEM_LAT cycles per access.
  - A branch or load-use pending in EX/ID is held frozen and evaluated in RUN after release.
- HALT: all five *_stop=1, halted=1. On resume=1: all stops 0 that cycle; next state RUN. resume outside HALT is ignored.
- Branch beats load-use because the ID instruction is wrong-path.
- ebreak beats a branch in EX; the branch is handled after resume.
- Back-to-back accesses: each access in MEM retriggers its own MEM_LAT-cycle wait.
- Reset asserted in MEM_WAIT or HALT returns to RUN immediately; in-flight cnt is discarded.

Optional Feature:
Macro PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments on each cycle in which pc_stop=1.
  - flush_count increments on each RUN row-3 flush.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: both ports remain present and are driven 32'b0; no counter flops are synthesized.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN/MEM_WAIT/HALT), REG_X0 = 5'd0 constant.
- One combinational sub-module, hazard_unit: load-use comparator producing a single load_use flag.
- The FSM, counter and output decode stay in pipeline_ctrl.

Test Plan:
- Load-use: ex_mem_to_reg=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> exactly one cycle of pc_stop=ifid_stop=idex_clr=1; with ex_rd=0 -> no stall.
- Branch vs load-use together: ex_branch_taken=1 with a matching load-use -> ifid_clr=idex_clr=1, pc_stop=0.
- MEM_LAT=2, load in MEM -> stops high for 2 cycles with memwb_clr=1, released on the 3rd cycle. Two consecutive loads -> 4 stall cycles total.
- MEM_LAT=0, store in MEM -> no stop ever asserted.
- ebreak in MEM -> exmem_clr pulse, then halted=1 and all stops high. Hold 10 cycles; resume=1 -> stops drop that cycle, halted=0 next cycle.
- rst asserted mid MEM_WAIT (cnt=1) -> outputs immediately all stops 0, all clr 1. After release the FSM is in RUN. With PIPE_CTRL_PERF_EN defined, the counters read 0.
